// File: rtl/button_debouncer.sv
// Push-button debouncer for the LFOSC (~10 kHz) domain.
//
// Synchronizes a raw, bouncing button pin and runs a four-state FSM. A level change is
// accepted only after it has been stable for DEBOUNCE_CYCLES clocks. The block reports
// accepted presses, releases and long holds as one-cycle strobes, and keeps a running
// press count.
//
// Ports:
//   clk           system clock (LFOSC domain)
//   rst_n         asynchronous active-low reset
//   btn_pin       raw asynchronous button pin
//   btn_level     debounced pressed level, 1 = pressed
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   long_pulse    one-cycle strobe when a hold reaches LONG_CYCLES
//   press_count   count of accepted presses, wraps modulo 2^CNT_W
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned LONG_CYCLES     = 10000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_pin,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StArming, StHeld, StDisarming} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic [DebW-1:0]    deb_q, deb_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic               long_done_q, long_done_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               long_q, long_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               act;

  // Pin level after synchronization, normalized so that 1 means pressed.
  assign act = sync2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Load the synchronizer with the released level so that a pin which is still
      // held after reset has to pass a full debounce again.
      sync1_q     <= ACTIVE_LOW;
      sync2_q     <= ACTIVE_LOW;
      state_q     <= StIdle;
      deb_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sync1_q     <= btn_pin;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    count_d     = count_q;

    // The hold timer runs in both pressed states, so a bounce during a hold does not
    // disturb the timing of the long-press strobe.
    if (state_q == StHeld || state_q == StDisarming) begin
      if (hold_q != HoldW'(LONG_CYCLES)) begin
        hold_d = hold_q + HoldW'(1);
      end
      if (hold_q == HoldW'(LONG_CYCLES - 1) && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (act) begin
          state_d = StArming;
          deb_d   = '0;
        end
      end
      StArming: begin
        if (!act) begin
          state_d = StIdle;
        end else if (deb_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
          state_d     = StHeld;
          level_d     = 1'b1;
          press_d     = 1'b1;
          count_d     = count_q + CNT_W'(1);
          hold_d      = '0;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DebW'(1);
        end
      end
      StHeld: begin
        if (!act) begin
          state_d = StDisarming;
          deb_d   = '0;
        end
      end
      StDisarming: begin
        if (act) begin
          state_d = StHeld;
        end else if (deb_q == DebW'(DEBOUNCE_CYCLES - 1)) begin
          // A long strobe set above on this same cycle is kept. Only the flag is cleared.
          state_d     = StIdle;
          level_d     = 1'b0;
          release_d   = 1'b1;
          long_done_d = 1'b0;
        end else begin
          deb_d = deb_q + DebW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
// Expected strobes are queued, with their cycle stamps, when the pin is driven. A monitor
// on the falling edge pops the queue and compares each strobe the DUT produces.
module tb_button_debouncer;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Long = 20;
  // Drive at a falling edge with cycle stamp N. The next rising edge samples the pin, and
  // the strobe becomes visible Deb+2 rising edges after that.
  localparam int Lat = Deb + 3;

  localparam int KPress = 0;
  localparam int KLong  = 1;
  localparam int KRel   = 2;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } evt_t;

  logic       clk;
  logic       rst_n;
  logic       btn_pin;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  evt_t       sb_q[$];
  int         cyc;
  int         n_vec;
  int         n_err;
  int         n_press;
  int         n_rel;
  logic [7:0] exp_count;

  button_debouncer #(
    .DEBOUNCE_CYCLES(Deb),
    .LONG_CYCLES    (Long),
    .ACTIVE_LOW     (1'b1),
    .CNT_W          (8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_pin      (btn_pin),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int cnt);
    evt_t e;
    e.kind = kind;
    e.cyc  = c;
    e.cnt  = cnt;
    sb_q.push_back(e);
  endtask

  // Compare one observed strobe against the oldest expected event.
  task automatic take(input int kind);
    evt_t e;
    if (sb_q.size() == 0) begin
      check("unexpected_pulse_kind", kind, -1);
    end else begin
      e = sb_q.pop_front();
      check("evt_kind", kind, e.kind);
      check("evt_cycle", cyc, e.cyc);
      if (kind == KPress) check("evt_press_count", int'(press_count), e.cnt);
    end
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      check("missed_evt_cycle", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    check("press_release_exclusive", int'(press_pulse & release_pulse), 0);
    if (press_pulse) begin
      n_press++;
      take(KPress);
    end
    if (long_pulse) take(KLong);
    if (release_pulse) begin
      n_rel++;
      take(KRel);
    end
  end

  // Call at a falling edge. Press for 'hold' cycles, then release and idle for 'gap' cycles.
  task automatic press_hold(input int hold, input int gap);
    int p;
    btn_pin   = 1'b0;
    p         = cyc + Lat;
    exp_count = exp_count + 8'd1;
    push(KPress, p, int'(exp_count));
    if (hold >= int'(Long)) push(KLong, p + int'(Long), 0);
    repeat (hold) @(negedge clk);
    check("level_held", int'(btn_level), 1);
    btn_pin = 1'b1;
    push(KRel, cyc + Lat, 0);
    repeat (gap) @(negedge clk);
    check("level_idle", int'(btn_level), 0);
    check("count_after", int'(press_count), int'(exp_count));
  endtask

  initial begin
    int p;
    int np0;
    int nr0;
    n_vec     = 0;
    n_err     = 0;
    n_press   = 0;
    n_rel     = 0;
    exp_count = 8'd0;
    rst_n     = 1'b0;
    btn_pin   = 1'b0;

    // Reset is held with the pin pressed: all outputs must stay low.
    repeat (10) begin
      @(negedge clk);
      check("rst_level", int'(btn_level), 0);
      check("rst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
      check("rst_count", int'(press_count), 0);
    end
    rst_n = 1'b1;
    press_hold(12, 12);

    // Clean press and release.
    press_hold(12, 12);

    // Bounce rejection while idle.
    for (int i = 0; i < 5; i++) begin
      btn_pin = 1'b0;
      repeat (2) @(negedge clk);
      btn_pin = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_level", int'(btn_level), 0);
    check("bounce_count", int'(press_count), int'(exp_count));

    // Bounce during a held press: no release. The hold timer keeps running, so the long
    // strobe still fires on time.
    btn_pin   = 1'b0;
    p         = cyc + Lat;
    exp_count = exp_count + 8'd1;
    push(KPress, p, int'(exp_count));
    push(KLong, p + int'(Long), 0);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      btn_pin = 1'b1;
      repeat (2) @(negedge clk);
      btn_pin = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("held_bounce_level", int'(btn_level), 1);
    btn_pin = 1'b1;
    push(KRel, cyc + Lat, 0);
    repeat (12) @(negedge clk);
    check("held_bounce_idle", int'(btn_level), 0);

    // Long press.
    press_hold(40, 12);

    // Asynchronous reset in the middle of a hold, with the pin kept pressed.
    btn_pin   = 1'b0;
    exp_count = exp_count + 8'd1;
    push(KPress, cyc + Lat, int'(exp_count));
    repeat (10) @(negedge clk);
    check("pre_rst_level", int'(btn_level), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_level", int'(btn_level), 0);
    check("async_rst_count", int'(press_count), 0);
    check("async_rst_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
    exp_count = 8'd0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    p         = cyc + Lat;
    exp_count = 8'd1;
    push(KPress, p, 1);
    push(KLong, p + int'(Long), 0);
    repeat (32) @(negedge clk);
    check("post_rst_count", int'(press_count), 1);
    btn_pin = 1'b1;
    push(KRel, cyc + Lat, 0);
    repeat (12) @(negedge clk);

    // Count wrap: start from zero and make 257 presses.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 8'd0;
    repeat (4) @(negedge clk);
    np0 = n_press;
    nr0 = n_rel;
    for (int i = 0; i < 257; i++) press_hold(8, 10);
    check("wrap_count", int'(press_count), 1);
    check("wrap_press_pulses", n_press - np0, 257);
    check("wrap_release_pulses", n_rel - nr0, 257);

    repeat (30) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
